// File: rtl/seq_divider_8_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DIV_WIDTH = 8;
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

endpackage

// File: rtl/seq_divider_8_sub_borrow_w.sv
// N-bit subtractor built as a + ~b + 1; borrow is the inverted carry out.
module sub_borrow_w #(
    parameter int N = 9
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_o
);

    logic [N:0] sum;

    assign sum      = {1'b0, a_i} + {1'b0, ~b_i} + {{N{1'b0}}, 1'b1};
    assign diff_o   = sum[N-1:0];
    assign borrow_o = ~sum[N];

endmodule

// File: rtl/seq_divider_8.sv
// Multi-cycle restoring divider, one shift-subtract step per clock.
// Optional signed (truncating) division when SIGNED_DIV_EN is defined.
module seq_divider_8
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] d_q, d_d;
    // Restored partial remainder is always below D, so WIDTH bits hold it.
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             restore;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] quot_fin;
    logic [WIDTH-1:0] rem_fin;

`ifdef SIGNED_DIV_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
`endif

    assign p_shift = {p_q, a_q[WIDTH-1]};

    sub_borrow_w #(
        .N(WIDTH + 1)
    ) u_sub (
        .a_i      (p_shift),
        .b_i      ({1'b0, d_q}),
        .diff_o   (diff),
        .borrow_o (borrow)
    );

    // A surviving difference must fit back into the WIDTH-bit remainder.
    assign restore = borrow | diff[WIDTH];
    assign a_next  = {a_q[WIDTH-2:0], ~restore};
    assign p_next  = restore ? p_shift[WIDTH-1:0] : diff[WIDTH-1:0];

`ifdef SIGNED_DIV_EN
    always_comb begin
        a_in     = (is_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
        d_in     = (is_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        if (state_q == IDLE && start && divisor != '0) begin
            qneg_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_d = is_signed & dividend[WIDTH-1];
        end
        quot_fin = qneg_q ? (~a_next + 1'b1) : a_next;
        rem_fin  = rneg_q ? (~p_next + 1'b1) : p_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
`else
    assign a_in     = dividend;
    assign d_in     = divisor;
    assign quot_fin = a_next;
    assign rem_fin  = p_next;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        d_d     = d_q;
        p_d     = p_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quot_d = '1;
                        rem_d  = dividend;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        a_d     = a_in;
                        d_d     = d_in;
                        p_d     = '0;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                a_d   = a_next;
                p_d   = p_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = IDLE;
                    quot_d  = quot_fin;
                    rem_d   = rem_fin;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            d_q     <= '0;
            p_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            d_q     <= d_d;
            p_q     <= p_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_8.sv
// Directed, table-driven check of seq_divider_8 (signed vectors when SIGNED_DIV_EN is defined).
module tb_seq_divider_8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       is_signed;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sgn;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } vec_t;

    seq_divider_8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SIGNED_DIV_EN
        .is_signed   (is_signed),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic sgn);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts rising edges after the current point until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        accept(v.a, v.b, v.sgn);
        chk({tag, " busy"}, busy, v.dbz ? 1'b0 : 1'b1);
        wait_done(lat);
        chk({tag, " latency"}, lat, v.dbz ? 0 : 8);
        chk({tag, " quotient"}, quotient, v.q);
        chk({tag, " remainder"}, remainder, v.r);
        chk({tag, " div_by_zero"}, div_by_zero, v.dbz);
        @(posedge clk);
        #1;
        chk({tag, " done pulse"}, done, 1'b0);
        chk({tag, " results held"}, {quotient, remainder}, {v.q, v.r});
    endtask

    vec_t uvec[10];
`ifdef SIGNED_DIV_EN
    vec_t svec[6];
`endif

    initial begin
        int lat;
        int pulses;

        uvec[0] = '{8'd100, 8'd7,   1'b0, 8'd14,  8'd2,   1'b0};
        uvec[1] = '{8'd5,   8'd0,   1'b0, 8'hFF,  8'd5,   1'b1};
        uvec[2] = '{8'd255, 8'd1,   1'b0, 8'hFF,  8'd0,   1'b0};
        uvec[3] = '{8'd3,   8'd200, 1'b0, 8'd0,   8'd3,   1'b0};
        uvec[4] = '{8'd200, 8'd200, 1'b0, 8'd1,   8'd0,   1'b0};
        uvec[5] = '{8'd255, 8'd16,  1'b0, 8'd15,  8'd15,  1'b0};
        uvec[6] = '{8'd0,   8'd5,   1'b0, 8'd0,   8'd0,   1'b0};
        uvec[7] = '{8'd128, 8'd3,   1'b0, 8'd42,  8'd2,   1'b0};
        uvec[8] = '{8'd254, 8'd255, 1'b0, 8'd0,   8'd254, 1'b0};
        uvec[9] = '{8'd1,   8'd1,   1'b0, 8'd1,   8'd0,   1'b0};
`ifdef SIGNED_DIV_EN
        svec[0] = '{8'h9C, 8'd7,   1'b1, 8'hF2, 8'hFE, 1'b0};
        svec[1] = '{8'h80, 8'hFF,  1'b1, 8'h80, 8'h00, 1'b0};
        svec[2] = '{8'd100, 8'hF9, 1'b1, 8'hF2, 8'd2,  1'b0};
        svec[3] = '{8'hF9, 8'd2,   1'b1, 8'hFD, 8'hFF, 1'b0};
        svec[4] = '{8'h9C, 8'd7,   1'b0, 8'd22, 8'd2,  1'b0};
        svec[5] = '{8'hFB, 8'd0,   1'b1, 8'hFF, 8'hFB, 1'b1};
`endif

        rst_n     = 1'b0;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset outputs", {quotient, remainder, div_by_zero}, 17'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(uvec[i], $sformatf("u%0d", i));

        // Back-to-back: new start in the done cycle is accepted.
        accept(8'd255, 8'd1, 1'b0);
        wait_done(lat);
        chk("b2b first latency", lat, 8);
        chk("b2b first result", {quotient, remainder}, {8'hFF, 8'h00});
        dividend = 8'd3;
        divisor  = 8'd200;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b second accepted", busy, 1'b1);
        chk("b2b done dropped", done, 1'b0);
        wait_done(lat);
        chk("b2b second latency", lat, 8);
        chk("b2b second result", {quotient, remainder}, {8'h00, 8'h03});

        // Start while busy (with changed operands) is ignored.
        @(posedge clk);
        #1;
        accept(8'd100, 8'd7, 1'b0);
        @(posedge clk);
        #1;
        dividend = 8'd9;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dividend = 8'd77;
        divisor  = 8'd0;
        wait_done(lat);
        chk("ignore latency", lat + 2, 8);
        chk("ignore result", {quotient, remainder, div_by_zero}, {8'd14, 8'd2, 1'b0});
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("ignore no second done", pulses, 0);
        chk("ignore stays idle", busy, 1'b0);

        // Asynchronous reset in the middle of a run.
        accept(8'd50, 8'd3, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort outputs", {quotient, remainder, div_by_zero}, 17'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(uvec[0], "after reset");

`ifdef SIGNED_DIV_EN
        for (int i = 0; i < 6; i++) run_vec(svec[i], $sformatf("s%0d", i));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
